// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and a small
// state-decode helper used by the top-level controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A new operation may be launched from either of these states.
  function automatic logic is_accept_state(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Team single-bit full adder; purely combinational bit slice.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full adder reused for WIDTH cycles, with a
// start/busy/done handshake and a result that only updates on completion.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one bit pair per cycle
// DONE  | sum/cout just updated; one-cycle done pulse
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last;

  fa u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept = is_accept_state(state) && start;
  assign last   = (state == RUN) && (cnt == LAST);

  // Shift the new sum bit in at the MSB; written this way so WIDTH=1 works.
  always_comb begin
    res_nxt            = res >> 1;
    res_nxt[WIDTH-1]   = fa_sum;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (accept) begin
        sa    <= a;
        sb    <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        carry <= fa_cout;
        res   <= res_nxt;
        cnt   <= cnt + 1'b1;
      end
      // Publish only on the final bit so partial results never leak out.
      if (last) begin
        sum  <= res_nxt;
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad = 0;
  logic [8:0] sbq8[$];
  logic [1:0] sbq1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns at the negedge right after the accepting edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
    if (push) sbq8.push_back(9'(a) + 9'(b) + 9'(c));
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input bit poke, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_n++;
      if (poke && lat == 2) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end
      if (poke && lat == 5) start8 = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result8(input string tag);
    logic [8:0] e;
    chk({tag, "_queued"}, 32'(sbq8.size() != 0), 32'd1);
    e = (sbq8.size() != 0) ? sbq8.pop_front() : 9'h000;
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_sum"}, 32'(sum8), 32'(e[7:0]));
    chk({tag, "_cout"}, 32'(cout8), 32'(e[8]));
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    int lat, bn;
    launch8(a, b, c, 1'b1);
    wait_done8(1'b0, lat, bn);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(bn), 32'd8);
    check_result8(tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy8), 32'd0);
  endtask

  task automatic do_op1(input logic a, input logic b, input logic c, input string tag);
    int lat;
    logic [1:0] e;
    sbq1.push_back(2'(a) + 2'(b) + 2'(c));
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    lat = 0;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    e = (sbq1.size() != 0) ? sbq1.pop_front() : 2'b00;
    chk({tag, "_sum"}, 32'(sum1), 32'(e[0]));
    chk({tag, "_cout"}, 32'(cout1), 32'(e[1]));
  endtask

  initial begin
    int lat, bn, extra, t;

    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_w1_sum", 32'(sum1), 32'd0);
    chk("rst_w1_busy", 32'(busy1), 32'd0);
    rstn = 1'b1;

    do_op8(8'h5A, 8'h33, 1'b0, "add_5a_33");
    do_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");

    // start asserted mid-run must be ignored
    launch8(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done8(1'b1, lat, bn);
    chk("ignore_lat", 32'(lat), 32'd8);
    check_result8("ignore");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("ignore_no_second_done", 32'(extra), 32'd0);

    // reset during the 4th RUN cycle aborts the operation
    launch8(8'hF0, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy8), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(cout8), 32'd0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    do_op8(8'h01, 8'h01, 1'b0, "after_abort");

    // back-to-back with start held high
    sbq8.push_back(9'h003);
    sbq8.push_back(9'h100);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    wait_done8(1'b0, lat, bn);
    chk("b2b_first_lat", 32'(lat), 32'd8);
    check_result8("b2b_first");
    a8 = 8'h80; b8 = 8'h80;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done8 && t < 40);
    chk("b2b_spacing", 32'(t), 32'd9);
    check_result8("b2b_second");
    start8 = 1'b0;
    @(negedge clk);
    chk("b2b_end_done", 32'(done8), 32'd0);
    chk("b2b_end_busy", 32'(busy8), 32'd0);
    chk("sb_drained", 32'(sbq8.size()), 32'd0);

    do_op1(1'b1, 1'b1, 1'b1, "w1_111");
    do_op1(1'b0, 1'b0, 1'b0, "w1_000");
    do_op1(1'b1, 1'b0, 1'b0, "w1_100");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first multi-bit adder built around the team's single-bit full adder (`fa`).
- Each cycle it:
  - presents one bit pair plus the stored carry to `fa`;
  - registers `fa`'s carry-out as the next carry-in;
  - shifts `fa`'s sum bit into a result register.
- Trades latency (WIDTH cycles) for a single full adder's worth of logic.
- A start/busy/done handshake lets a controller or testbench launch one addition at a time.

Parameters:
- `WIDTH`, 8, operand and result width in bits (≥1).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rstn`  input  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `start`  input  1  request to begin an addition; sampled only when idle or done.
- `a`  input  WIDTH  operand A; captured on accepted `start`.
- `b`  input  WIDTH  operand B; captured on accepted `start`.
- `cin`  input  1  initial carry-in; captured on accepted `start`.
- `busy`  output  1  high while an addition is in progress (RUN state).
- `done`  output  1  one-cycle pulse: `sum`/`cout` just updated with a new result.
- `sum`  output  WIDTH  result of `a + b + cin` mod 2^WIDTH; holds last result.
- `cout`  output  1  carry out of bit WIDTH-1; holds last result.

Behaviour:
- Reset (`rstn`=0 at an edge):
  - state → IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - internal shift registers, carry register and counter → 0.
  - Applies in any state; an in-flight addition is aborted with no `done` pulse.
- States:
  - IDLE: waiting.
  - RUN: one bit per cycle.
  - DONE: result published for one cycle.
- IDLE → RUN on edge with `start`=1:
  - load `a`→`sa`, `b`→`sb`, `cin`→`carry`, `cnt`=0;
  - `busy`=1 from the next cycle.
- RUN, each edge:
  - `fa` inputs = `sa[0]`, `sb[0]`, `carry`;
  - `carry` ← `fa.cout`;
  - `sa`, `sb` shift right by 1;
  - `res` ← {`fa.sum`, `res[WIDTH-1:1]`} (right-shift in at MSB);
  - `cnt` ← `cnt`+1.
- RUN → DONE on the edge where `cnt`==WIDTH-1 (the WIDTH-th bit):
  - `sum` ← final `res` including the current bit;
  - `cout` ← `fa.cout`;
  - `done`=1, `busy`=0.
- `sum`/`cout` change only on this transition or on reset. Partial results are never visible.
- DONE:
  - `done` high for exactly one cycle.
  - With `start`=1: behave as IDLE accept, going directly to RUN (back-to-back, no idle gap).
  - Otherwise → IDLE.
- Latency: `start` accepted at edge k → `done`=1 during the cycle after edge k+WIDTH; `sum`/`cout` valid from that same cycle.
- Throughput: one addition per WIDTH+1 cycles.
- `start` while RUN: ignored; operands and inputs are not re-captured. `a`/`b`/`cin` may change freely after capture.
- WIDTH=1: RUN lasts one cycle; same rules apply.
- Counter width: `$clog2(WIDTH+1)`; it never wraps within an operation.
- `fa` is purely combinational; carry is the only loop-carried state, held in a flop.

Decomposition:
- Package `serial_adder_pkg`:
  - state encoding `IDLE`=2'b00, `RUN`=2'b01, `DONE`=2'b10, as a typedef enum;
  - default illegal-state recovery → IDLE.
- Sub-module: exactly one `fa` instance (existing team full adder) for the bit-slice arithmetic.
- FSM, shift registers and counter live in `serial_adder`; no further hierarchy.

Test Plan:
- WIDTH=8, `a`=8'h5A, `b`=8'h33, `cin`=0, pulse `start` → `done` pulse 9 cycles after the start edge; `sum`=8'h8D, `cout`=0; `busy` high for exactly 8 cycles.
- `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1. Then `a`=8'hFF, `b`=8'hFF, `cin`=1 → `sum`=8'hFF, `cout`=1 (full carry ripple).
- Start 8'h10+8'h20. During RUN, assert `start` with `a`=8'hAA, `b`=8'h55 and change inputs → single `done`, `sum`=8'h30, `cout`=0; second request not performed.
- Assert `rstn`=0 for one edge at the 4th RUN cycle of 8'hF0+8'h0F → `busy`=0, `sum`=0, `cout`=0 next cycle, no `done`. A subsequent start of 8'h01+8'h01 → `sum`=8'h02.
- Hold `start`=1 continuously with operand pairs (8'h01, 8'h02), then (8'h80, 8'h80) presented at each DONE cycle → `done` pulses 9 cycles apart; results 8'h03/`cout`=0, then 8'h00/`cout`=1.
- WIDTH=1 build: `a`=1, `b`=1, `cin`=1 → `done` 2 cycles after the start edge, `sum`=1, `cout`=1; and `a`=0, `b`=0, `cin`=0 → `sum`=0, `cout`=0.
